prog_host: RTL and testbench

PROG_HOST -- requirements
Module: prog_host

---
 rtl/prog_host.sv | 178 +++++++++++++++++
 tb/tb_prog_host.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_host.sv
// Test-host sequencer: loads a message and a pattern byte into data memory,
// clears the result slots, requests a processor run, waits for completion
// (bounded by a timeout) and reads the three result bytes back.
module prog_host #(
  parameter int unsigned MSG_BYTES = 32,
  parameter int unsigned PAT_ADDR  = 32,
  parameter int unsigned RES_BASE  = 33,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pat_in,
  input  logic       msg_valid,
  input  logic [7:0] msg_data,
  output logic       msg_ready,
  output logic       dm_we,
  output logic [7:0] dm_addr,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata,
  output logic       dut_req,
  input  logic       dut_done,
  output logic [7:0] ctb,
  output logic [7:0] cto,
  output logic [7:0] cts,
  output logic       res_valid,
  output logic       err,
  output logic       busy
);

  // One counter serves both the byte index in LOAD and the timeout in WAIT.
  localparam int unsigned CntMax = (TIMEOUT > MSG_BYTES) ? TIMEOUT : MSG_BYTES;
  localparam int unsigned CntW   = ($clog2(CntMax) + 1 > 8) ? $clog2(CntMax) + 1 : 8;
  localparam logic [CntW-1:0] LastByte = CntW'(MSG_BYTES - 1);
  localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);
  localparam logic [7:0]      PatAddr  = 8'(PAT_ADDR);
  localparam logic [7:0]      ResBase  = 8'(RES_BASE);

  typedef enum logic [2:0] {
    StIdle, StLoad, StWpat, StClr, StReq, StWait, StRd, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      pat_q, pat_d;
  logic [7:0]      ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic            err_q, err_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: if (msg_valid && (cnt_q == LastByte)) state_d = StWpat;
      StWpat: state_d = StClr;
      StClr:  if (idx_q == 2'd2) state_d = StReq;
      StReq:  state_d = StWait;
      StWait: begin
        if (dut_done) begin
          state_d = StRd;
        end else if (cnt_q == LastWait) begin
          state_d = StFin;
        end
      end
      StRd:   if (idx_q == 2'd2) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: counters, captured pattern, results and error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      ctb_q <= '0;
      cto_q <= '0;
      cts_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      ctb_q <= ctb_d;
      cto_q <= cto_d;
      cts_q <= cts_d;
      err_q <= err_d;
    end
  end

  // Datapath next-state; idx wraps to 0 after CLR so RD starts at slot 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    pat_d = pat_q;
    ctb_d = ctb_q;
    cto_d = cto_q;
    cts_d = cts_q;
    err_d = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d = pat_in;
          cnt_d = '0;
          idx_d = '0;
        end
      end
      StLoad: if (msg_valid) cnt_d = cnt_q + 1'b1;
      StClr:  idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      StReq:  cnt_d = '0;
      StWait: begin
        if (!dut_done) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastWait) err_d = 1'b1;
        end
      end
      StRd: begin
        case (idx_q)
          2'd0:    ctb_d = dm_rdata;
          2'd1:    cto_d = dm_rdata;
          default: cts_d = dm_rdata;
        endcase
        idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        if (idx_q == 2'd2) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    msg_ready = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dut_req   = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StLoad: begin
        msg_ready = 1'b1;
        dm_we     = msg_valid;
        dm_addr   = cnt_q[7:0];
        dm_wdata  = msg_data;
      end
      StWpat: begin
        dm_we    = 1'b1;
        dm_addr  = PatAddr;
        dm_wdata = pat_q;
      end
      StClr: begin
        dm_we   = 1'b1;
        dm_addr = ResBase + {6'd0, idx_q};
      end
      StReq:  dut_req = 1'b1;
      StRd:   dm_addr = ResBase + {6'd0, idx_q};
      StFin:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign ctb  = ctb_q;
  assign cto  = cto_q;
  assign cts  = cts_q;
  assign err  = err_q;

endmodule

// File: tb/tb_prog_host.sv
// Bench for prog_host: memory + processor environment, table-driven runs,
// randomized runs against a run-level model, and a mid-load reset sequence.
module tb_prog_host;

  localparam int unsigned MsgBytes = 32;
  localparam int unsigned PatAddr  = 32;
  localparam int unsigned ResBase  = 33;
  localparam int unsigned Timeout  = 4096;

  logic       clk = 1'b0;
  logic       reset, start, msg_valid, msg_ready, dm_we, dut_req, dut_done;
  logic       res_valid, err, busy;
  logic [7:0] pat_in, msg_data, dm_addr, dm_wdata, dm_rdata, ctb, cto, cts;

  always #5 clk = ~clk;

  prog_host #(
    .MSG_BYTES(MsgBytes), .PAT_ADDR(PatAddr), .RES_BASE(ResBase), .TIMEOUT(Timeout)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pat_in(pat_in),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dut_req(dut_req), .dut_done(dut_done), .ctb(ctb), .cto(cto), .cts(cts),
    .res_valid(res_valid), .err(err), .busy(busy)
  );

  // Environment: memory, processor model, event monitor.
  logic [7:0] mem [256];
  logic       done_q, force_done, proc_pend;
  int         proc_delay, proc_cnt;
  logic [7:0] proc_r0, proc_r1, proc_r2;
  int         cyc = 0, req_cnt = 0, rv_cnt = 0, busy_cnt = 0, req_cyc = 0, rv_cyc = 0;
  logic [7:0] rv_ctb, rv_cto, rv_cts;
  logic       rv_err;
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  assign dut_done = done_q | force_done;
  assign dm_rdata = mem[dm_addr];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
      wr_addr_q.push_back(dm_addr);
      wr_data_q.push_back(dm_wdata);
    end
    if (dut_req) begin
      req_cnt <= req_cnt + 1;
      req_cyc <= cyc;
    end
    if (busy && !res_valid) busy_cnt <= busy_cnt + 1;
    if (res_valid) begin
      rv_cnt <= rv_cnt + 1;
      rv_cyc <= cyc;
      rv_ctb <= ctb;
      rv_cto <= cto;
      rv_cts <= cts;
      rv_err <= err;
      done_q <= 1'b0;
    end
    // Processor: done (and results in memory) appear proc_delay cycles after req.
    if (!reset) begin
      done_q    <= 1'b0;
      proc_pend <= 1'b0;
    end else if ((dut_req && proc_delay == 0) || (proc_pend && proc_cnt == 1)) begin
      done_q         <= 1'b1;
      proc_pend      <= 1'b0;
      mem[ResBase]   <= proc_r0;
      mem[ResBase+1] <= proc_r1;
      mem[ResBase+2] <= proc_r2;
    end else if (dut_req && proc_delay > 0) begin
      proc_cnt  <= proc_delay;
      proc_pend <= 1'b1;
    end else if (proc_pend) begin
      proc_cnt <= proc_cnt - 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] pat;
    int         mode;       // 0 back-to-back, 1 alternate cycles, 2 random valid
    logic [7:0] fill;
    bit         rand_data;
    int         delay;      // cycles from req to done; <0 means never
    logic [7:0] r0, r1, r2;
    bit         exp_err;
    logic [7:0] e0, e1, e2;
    bit         pulse_start;
    bit         early_done;
  } vec_t;

  // Run-level model: results survive a timed-out run, reset clears them.
  logic [7:0] m_ctb = 8'd0, m_cto = 8'd0, m_cts = 8'd0;

  task automatic run_case(input vec_t v, input string tag);
    int         rv0, req0, bc0, wr0, load_cycles, sent, budget, mism, w_cyc, rd_cyc;
    bit         val, pulsed, exp_err;
    logic [7:0] b;
    logic [7:0] msg [$];
    proc_delay = v.delay;
    proc_r0 = v.r0;
    proc_r1 = v.r1;
    proc_r2 = v.r2;
    force_done = v.early_done;
    budget = 0;
    while (busy && budget < 100) begin
      tick();
      budget++;
    end
    rv0 = rv_cnt;
    req0 = req_cnt;
    bc0 = busy_cnt;
    wr0 = wr_addr_q.size();
    start = 1'b1;
    pat_in = v.pat;
    tick();
    start = 1'b0;
    pat_in = 8'($urandom);
    sent = 0;
    load_cycles = 0;
    while (sent < MsgBytes && load_cycles < 2000) begin
      case (v.mode)
        0:       val = 1'b1;
        1:       val = (load_cycles % 2 == 0);
        default: val = 1'($urandom_range(0, 1));
      endcase
      msg_valid = val;
      if (val) begin
        b = v.rand_data ? 8'($urandom) : v.fill;
        msg.push_back(b);
        msg_data = b;
        sent++;
      end else begin
        msg_data = 8'($urandom);
      end
      load_cycles++;
      tick();
    end
    msg_valid = 1'b0;
    budget = 0;
    pulsed = 1'b0;
    while (rv_cnt == rv0 && budget < Timeout + 200) begin
      if (v.pulse_start && !pulsed && req_cnt != req0) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      budget++;
    end
    start = 1'b0;
    check({tag, "_res_valid_seen"}, rv_cnt - rv0, 1);
    repeat (4) tick();
    force_done = 1'b0;

    exp_err = (v.delay < 0);
    w_cyc  = exp_err ? Timeout : ((v.delay == 0) ? 1 : v.delay);
    rd_cyc = exp_err ? 0 : 3;
    check({tag, "_one_res_valid"}, rv_cnt - rv0, 1);
    check({tag, "_one_req_cycle"}, req_cnt - req0, 1);
    check({tag, "_err"}, rv_err, v.exp_err);
    check({tag, "_ctb"}, rv_ctb, v.e0);
    check({tag, "_cto"}, rv_cto, v.e1);
    check({tag, "_cts"}, rv_cts, v.e2);
    check({tag, "_req_to_valid"}, rv_cyc - req_cyc, 1 + w_cyc + rd_cyc);
    check({tag, "_busy_cycles"}, busy_cnt - bc0, load_cycles + 5 + w_cyc + rd_cyc);
    if (v.mode == 0 && v.delay == 0)
      check({tag, "_min_latency"}, busy_cnt - bc0, MsgBytes + 9);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_write_count"}, wr_addr_q.size() - wr0, MsgBytes + 4);
    mism = 0;
    if (wr_addr_q.size() - wr0 == MsgBytes + 4) begin
      for (int i = 0; i < MsgBytes + 4; i++) begin
        logic [7:0] ea, ed;
        if (i < MsgBytes) begin
          ea = 8'(i);
          ed = msg[i];
        end else if (i == MsgBytes) begin
          ea = 8'(PatAddr);
          ed = v.pat;
        end else begin
          ea = 8'(ResBase + i - MsgBytes - 1);
          ed = 8'd0;
        end
        if (wr_addr_q[wr0+i] !== ea || wr_data_q[wr0+i] !== ed) mism++;
      end
    end else begin
      mism = -1;
    end
    check({tag, "_write_seq_mismatches"}, mism, 0);
    if (!exp_err) begin
      m_ctb = v.r0;
      m_cto = v.r1;
      m_cts = v.r2;
    end
  endtask

  vec_t tbl [6];

  initial begin
    int wr0;
    vec_t rv;
    tbl[0] = '{8'hF8, 0, 8'hFF, 1'b0, 20, 8'd128, 8'd32, 8'd224, 1'b0,
               8'd128, 8'd32, 8'd224, 1'b0, 1'b0};
    tbl[1] = '{8'h5A, 1, 8'h00, 1'b1, 3, 8'd1, 8'd2, 8'd3, 1'b0,
               8'd1, 8'd2, 8'd3, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 0, 8'h00, 1'b1, -1, 8'd77, 8'd66, 8'd55, 1'b1,
               8'd1, 8'd2, 8'd3, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 0, 8'h00, 1'b1, 7, 8'd9, 8'd8, 8'd7, 1'b0,
               8'd9, 8'd8, 8'd7, 1'b1, 1'b0};
    tbl[4] = '{8'hC3, 0, 8'h00, 1'b1, 0, 8'h11, 8'h22, 8'h33, 1'b0,
               8'h11, 8'h22, 8'h33, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 0, 8'h5A, 1'b0, 0, 8'hA0, 8'hB1, 8'hC2, 1'b0,
               8'hA0, 8'hB1, 8'hC2, 1'b0, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    pat_in = 8'd0;
    msg_valid = 1'b0;
    msg_data = 8'd0;
    force_done = 1'b0;
    proc_delay = -1;
    proc_r0 = 8'd0;
    proc_r1 = 8'd0;
    proc_r2 = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ctrl", {msg_ready, dm_we, dut_req, res_valid, err, busy}, 0);
    check("reset_addr_wdata", {dm_addr, dm_wdata}, 0);
    check("reset_results", {ctb, cto, cts}, 0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of LOAD, with the byte counter at 10.
    start = 1'b1;
    pat_in = 8'hAA;
    tick();
    start = 1'b0;
    wr0 = wr_addr_q.size();
    for (int i = 0; i < 10; i++) begin
      msg_valid = 1'b1;
      msg_data = 8'(i + 1);
      tick();
    end
    msg_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    msg_valid = 1'b1;
    msg_data = 8'h55;
    @(negedge clk);
    check("midload_reset_busy", busy, 0);
    check("midload_reset_we", dm_we, 0);
    msg_valid = 1'b0;
    repeat (20) tick();
    check("midload_reset_writes", wr_addr_q.size() - wr0, 10);
    check("midload_reset_results", {ctb, cto, cts, 7'd0, err}, 0);
    m_ctb = 8'd0;
    m_cto = 8'd0;
    m_cts = 8'd0;

    for (int i = 4; i < 6; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.pat = 8'($urandom);
      rv.mode = 2;
      rv.fill = 8'd0;
      rv.rand_data = 1'b1;
      rv.delay = int'($urandom_range(0, 40));
      rv.r0 = 8'($urandom);
      rv.r1 = 8'($urandom);
      rv.r2 = 8'($urandom);
      rv.exp_err = 1'b0;
      rv.e0 = rv.r0;
      rv.e1 = rv.r1;
      rv.e2 = rv.r2;
      rv.pulse_start = 1'($urandom_range(0, 1));
      rv.early_done = 1'b0;
      run_case(rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
